ma_stage_ctrl: RTL and testbench
================================

MA_STAGE_CTRL -- requirements
Module: ma_stage_ctrl

Interface
REQ-001 SHALL have parameter NBITS, default 32, data/address width.
REQ-002 SHALL have ports: i_clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have: i_rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have: i_valid  in  1  EX/MA entry holds a valid instruction.
REQ-005 SHALL have: i_flg_mem_op  in  1  1 = memory instruction.
REQ-006 SHALL have: i_flg_mem_type  in  1  0 = load, 1 = store.
REQ-007 SHALL have: i_flg_mem_size  in  2  00 byte, 01 half, 11 word, 10 treated as word.
REQ-008 SHALL have: i_flg_unsign  in  1  1 = zero-extend loads, 0 = sign-extend.
REQ-009 SHALL have: i_eff_addr, i_ALU_rslt, i_store_data  in  NBITS each  effective address, ALU result, store source.
REQ-010 SHALL have: i_rd, i_rt  in  5 each; i_flg_ALU_dst  in  2  (00 rd, 01 rt, 10 r31, 11 no write).
REQ-011 SHALL have memory side: o_mem_req out 1, o_mem_we out 1, o_mem_addr out NBITS (bits[1:0]=0), o_mem_be out 4, o_mem_wdata out NBITS, i_mem_ack in 1, i_mem_rdata in NBITS.
REQ-012 SHALL have pipeline side: o_stall out 1, o_valid out 1, o_wb_en out 1, o_wb_reg out 5, o_wb_data out NBITS, o_misaligned out 1.

Function
REQ-013 SHALL implement FSM states IDLE and WAIT.
REQ-014 Non-memory valid instruction in IDLE: o_valid=1 next cycle, o_wb_data=i_ALU_rslt, o_wb_reg per i_flg_ALU_dst, o_wb_en=0 iff dst=11; latency 1; no stall.
REQ-015 Aligned memory instruction in IDLE: o_stall=1 combinationally that cycle; next edge registers o_mem_req=1 plus addr/we/be/wdata and enters WAIT.
REQ-016 In WAIT: o_stall=1, request signals held stable until the cycle i_mem_ack=1 is sampled; that edge drops o_mem_req, returns to IDLE, pulses o_valid for exactly one cycle.
REQ-017 i_mem_ack SHALL be ignored in IDLE; upstream holds inputs stable while o_stall=1.
REQ-018 Misalignment (half with addr[0]=1, word with addr[1:0]!=00): no memory request; one-cycle o_valid with o_misaligned=1, o_wb_en=0.
REQ-019 Byte lanes little-endian: byte lane = addr[1:0], half lane = addr[1]; stores replicate data across lanes, o_mem_be = 0001<<addr[1:0] (byte), 0011<<{addr[1],0} (half), 1111 (word).
REQ-020 Loads: extract lane from i_mem_rdata captured at ack, extend to NBITS per i_flg_unsign; o_wb_reg=i_rt, o_wb_en=1.
REQ-021 Stores: o_wb_en=0; o_wb_data=0.
REQ-022 i_valid=0 in IDLE: o_valid=0 next cycle, no request.
REQ-023 Back-to-back memory instructions SHALL each incur a full request/ack sequence; the next is accepted in the cycle after o_valid.

Reset
REQ-024 i_rst=0 SHALL immediately force IDLE and all outputs to 0 (o_mem_req, o_stall, o_valid, o_wb_*, o_misaligned, mem address/data/be).
REQ-025 Reset during WAIT SHALL abandon the access; an ack arriving after reset release in IDLE is ignored.

Verification
REQ-026 ALU op, i_ALU_rslt=0x12345678, dst=00, i_rd=5 -> next cycle o_valid=1, o_wb_reg=5, o_wb_data=0x12345678, o_stall never 1.
REQ-027 Signed byte load addr 0x103, rdata 0x80FFFFFF, ack after 3 WAIT cycles -> o_mem_addr=0x100, be=0000 read, o_wb_data=0xFFFFFF80, o_valid one cycle after ack.
REQ-028 Unsigned half store addr 0x202, data 0x0000BEEF -> o_mem_we=1, be=1100, wdata=0xBEEFBEEF, o_wb_en=0.
REQ-029 Word load addr 0x301 -> o_misaligned=1, o_valid=1 one cycle, o_mem_req stays 0.
REQ-030 Assert i_rst=0 in WAIT, release, then pulse i_mem_ack -> all outputs 0, no o_valid.

Source files
------------

// File: rtl/ma_stage_ctrl.sv
// Memory-access stage controller: passes ALU results through in one cycle and runs
// a stalled request/ack handshake for aligned loads and stores.
module ma_stage_ctrl #(
    parameter int NBITS = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic             i_flg_mem_op,
    input  logic             i_flg_mem_type,
    input  logic [1:0]       i_flg_mem_size,
    input  logic             i_flg_unsign,
    input  logic [NBITS-1:0] i_eff_addr,
    input  logic [NBITS-1:0] i_ALU_rslt,
    input  logic [NBITS-1:0] i_store_data,
    input  logic [4:0]       i_rd,
    input  logic [4:0]       i_rt,
    input  logic [1:0]       i_flg_ALU_dst,
    output logic             o_mem_req,
    output logic             o_mem_we,
    output logic [NBITS-1:0] o_mem_addr,
    output logic [3:0]       o_mem_be,
    output logic [NBITS-1:0] o_mem_wdata,
    input  logic             i_mem_ack,
    input  logic [NBITS-1:0] i_mem_rdata,
    output logic             o_stall,
    output logic             o_valid,
    output logic             o_wb_en,
    output logic [4:0]       o_wb_reg,
    output logic [NBITS-1:0] o_wb_data,
    output logic             o_misaligned
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t     state, next_state;
    logic       done;
    logic       accept, misaligned, start_mem, mem_done;
    logic       op_store, op_unsign;
    logic [1:0] op_size, op_lane;
    logic [4:0] op_rt;
    logic [3:0] req_be;
    logic [NBITS-1:0] req_wdata, load_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // The instruction that just completed is still on the inputs during its o_valid
    // cycle, so acceptance is blocked until upstream has advanced.
    assign accept     = (state == S_IDLE) && !done && i_valid;
    assign misaligned = ((i_flg_mem_size == 2'b01) && i_eff_addr[0]) ||
                        (i_flg_mem_size[1] && (i_eff_addr[1:0] != 2'b00));
    assign start_mem  = accept && i_flg_mem_op && !misaligned;
    assign mem_done   = (state == S_WAIT) && i_mem_ack;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        o_stall    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_mem) begin
                    next_state = S_WAIT;
                    o_stall    = 1'b1;
                end
            end
            S_WAIT: begin
                o_stall = 1'b1;
                if (i_mem_ack) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
        if (!i_rst) o_stall = 1'b0;
    end

    // Stores replicate the source across all lanes; loads drive no byte enables.
    always_comb begin
        req_be    = 4'b0000;
        req_wdata = '0;
        if (i_flg_mem_type) begin
            case (i_flg_mem_size)
                2'b00: begin
                    req_be    = 4'b0001 << i_eff_addr[1:0];
                    req_wdata = {(NBITS/8){i_store_data[7:0]}};
                end
                2'b01: begin
                    req_be    = 4'b0011 << {i_eff_addr[1], 1'b0};
                    req_wdata = {(NBITS/16){i_store_data[15:0]}};
                end
                default: begin
                    req_be    = 4'b1111;
                    req_wdata = i_store_data;
                end
            endcase
        end
    end

    always_comb begin
        ld_byte   = i_mem_rdata[{op_lane, 3'b000} +: 8];
        ld_half   = i_mem_rdata[{op_lane[1], 4'b0000} +: 16];
        load_data = i_mem_rdata;
        case (op_size)
            2'b00:   load_data = op_unsign ? {{(NBITS-8){1'b0}}, ld_byte}
                                           : {{(NBITS-8){ld_byte[7]}}, ld_byte};
            2'b01:   load_data = op_unsign ? {{(NBITS-16){1'b0}}, ld_half}
                                           : {{(NBITS-16){ld_half[15]}}, ld_half};
            default: load_data = i_mem_rdata;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_mem_req    <= 1'b0;
            o_mem_we     <= 1'b0;
            o_mem_addr   <= '0;
            o_mem_be     <= 4'b0000;
            o_mem_wdata  <= '0;
            o_valid      <= 1'b0;
            o_wb_en      <= 1'b0;
            o_wb_reg     <= 5'd0;
            o_wb_data    <= '0;
            o_misaligned <= 1'b0;
            done         <= 1'b0;
            op_store     <= 1'b0;
            op_unsign    <= 1'b0;
            op_size      <= 2'b00;
            op_lane      <= 2'b00;
            op_rt        <= 5'd0;
        end else begin
            o_valid      <= 1'b0;
            o_wb_en      <= 1'b0;
            o_wb_reg     <= 5'd0;
            o_wb_data    <= '0;
            o_misaligned <= 1'b0;
            done         <= 1'b0;
            if (accept && !i_flg_mem_op) begin
                o_valid   <= 1'b1;
                o_wb_data <= i_ALU_rslt;
                o_wb_en   <= (i_flg_ALU_dst != 2'b11);
                case (i_flg_ALU_dst)
                    2'b00:   o_wb_reg <= i_rd;
                    2'b01:   o_wb_reg <= i_rt;
                    2'b10:   o_wb_reg <= 5'd31;
                    default: o_wb_reg <= 5'd0;
                endcase
            end else if (accept && misaligned) begin
                o_valid      <= 1'b1;
                o_misaligned <= 1'b1;
            end else if (start_mem) begin
                o_mem_req   <= 1'b1;
                o_mem_we    <= i_flg_mem_type;
                o_mem_addr  <= {i_eff_addr[NBITS-1:2], 2'b00};
                o_mem_be    <= req_be;
                o_mem_wdata <= req_wdata;
                op_store    <= i_flg_mem_type;
                op_unsign   <= i_flg_unsign;
                op_size     <= i_flg_mem_size;
                op_lane     <= i_eff_addr[1:0];
                op_rt       <= i_rt;
            end
            if (mem_done) begin
                o_mem_req   <= 1'b0;
                o_mem_we    <= 1'b0;
                o_mem_addr  <= '0;
                o_mem_be    <= 4'b0000;
                o_mem_wdata <= '0;
                o_valid     <= 1'b1;
                done        <= 1'b1;
                if (!op_store) begin
                    o_wb_en   <= 1'b1;
                    o_wb_reg  <= op_rt;
                    o_wb_data <= load_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_ma_stage_ctrl.sv
// Scoreboard bench for ma_stage_ctrl: expected write-back results are queued as each
// instruction is driven and compared whenever the DUT pulses o_valid.
module tb_ma_stage_ctrl;

    logic        clk;
    logic        rst;
    logic        valid, mem_op, mem_type, unsign;
    logic [1:0]  mem_size, alu_dst;
    logic [31:0] eff_addr, alu_rslt, store_data, mem_rdata;
    logic [4:0]  rd, rt;
    logic        mem_ack;
    logic        mem_req, mem_we, stall, out_valid, wb_en, misaligned;
    logic [31:0] mem_addr, mem_wdata, wb_data;
    logic [3:0]  mem_be;
    logic [4:0]  wb_reg;

    typedef struct {
        logic        mis;
        logic        wb_en;
        logic        chk_reg;
        logic [4:0]  wb_reg;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    ma_stage_ctrl #(.NBITS(32)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_flg_mem_op(mem_op),
        .i_flg_mem_type(mem_type), .i_flg_mem_size(mem_size), .i_flg_unsign(unsign),
        .i_eff_addr(eff_addr), .i_ALU_rslt(alu_rslt), .i_store_data(store_data),
        .i_rd(rd), .i_rt(rt), .i_flg_ALU_dst(alu_dst),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_be(mem_be),
        .o_mem_wdata(mem_wdata), .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
        .o_stall(stall), .o_valid(out_valid), .o_wb_en(wb_en), .o_wb_reg(wb_reg),
        .o_wb_data(wb_data), .o_misaligned(misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Every o_valid pulse must match the oldest queued expectation.
    always @(posedge clk) begin
        #1;
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_valid", 32'(out_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("wb_misaligned", 32'(misaligned), 32'(e.mis));
                checkOutput("wb_en", 32'(wb_en), 32'(e.wb_en));
                checkOutput("wb_data", wb_data, e.data);
                if (e.chk_reg) checkOutput("wb_reg", 32'(wb_reg), 32'(e.wb_reg));
            end
        end
    end

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                               input logic [31:0] addr, input logic [31:0] rdata);
        logic [31:0] sh;
        sh = rdata >> (8 * addr[1:0]);
        if (size == 2'b00) return uns ? (sh & 32'h0000_00FF) : 32'(signed'(sh[7:0]));
        if (size == 2'b01) return uns ? (sh & 32'h0000_FFFF) : 32'(signed'(sh[15:0]));
        return rdata;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   return (lane == 2'd0) ? 4'b0001 : (lane == 2'd1) ? 4'b0010 :
                            (lane == 2'd2) ? 4'b0100 : 4'b1000;
            2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] d);
        if (size == 2'b00) return {4{d[7:0]}};
        if (size == 2'b01) return {2{d[15:0]}};
        return d;
    endfunction

    task automatic applyStimulus(input logic [31:0] rslt, input logic [1:0] dst,
                                 input logic [4:0] r_d, input logic [4:0] r_t);
        exp_t e;
        @(negedge clk);
        valid = 1'b1; mem_op = 1'b0; alu_rslt = rslt; alu_dst = dst; rd = r_d; rt = r_t;
        e.mis = 1'b0; e.wb_en = (dst != 2'b11); e.chk_reg = (dst != 2'b11);
        e.wb_reg = (dst == 2'b00) ? r_d : (dst == 2'b01) ? r_t : 5'd31;
        e.data = rslt;
        sb.push_back(e);
        #1 checkOutput("alu_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1 valid = 1'b0;
        checkOutput("alu_no_req", 32'(mem_req), 32'd0);
    endtask

    task automatic mem_instr(input logic st, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] sdata,
                             input logic [31:0] rdata, input int waits, input logic [4:0] r_t);
        exp_t e;
        logic mis;
        mis = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
        @(negedge clk);
        valid = 1'b1; mem_op = 1'b1; mem_type = st; mem_size = size; unsign = uns;
        eff_addr = addr; store_data = sdata; rt = r_t; rd = r_t + 5'd1; alu_dst = 2'b00;
        alu_rslt = 32'hAAAA_5555;
        if (mis) begin
            e.mis = 1'b1; e.wb_en = 1'b0; e.chk_reg = 1'b0; e.wb_reg = 5'd0; e.data = 32'd0;
            sb.push_back(e);
            @(posedge clk);
            #1 valid = 1'b0;
            checkOutput("mis_no_req", 32'(mem_req), 32'd0);
            @(posedge clk);
            #1 checkOutput("mis_no_req_late", 32'(mem_req), 32'd0);
            return;
        end
        #1 checkOutput("stall_comb", 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("req", 32'(mem_req), 32'd1);
        checkOutput("we", 32'(mem_we), 32'(st));
        checkOutput("addr", mem_addr, {addr[31:2], 2'b00});
        checkOutput("be", 32'(mem_be), st ? 32'(model_be(size, addr[1:0])) : 32'd0);
        if (st) checkOutput("wdata", mem_wdata, model_wdata(size, sdata));
        for (int i = 0; i < waits; i++) begin
            @(posedge clk);
            #1;
            checkOutput("req_hold", 32'(mem_req), 32'd1);
            checkOutput("addr_hold", mem_addr, {addr[31:2], 2'b00});
            checkOutput("stall_wait", 32'(stall), 32'd1);
        end
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = rdata;
        e.mis = 1'b0; e.wb_en = !st; e.chk_reg = !st; e.wb_reg = r_t;
        e.data = st ? 32'd0 : model_load(size, uns, addr, rdata);
        sb.push_back(e);
        @(posedge clk);
        #1 checkOutput("req_drop", 32'(mem_req), 32'd0);
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 32'h5A5A_5A5A;
        @(posedge clk);
        #1 checkOutput("no_rerequest", 32'(mem_req), 32'd0);
        valid = 1'b0;
    endtask

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0; valid = 1'b1; mem_op = 1'b1; mem_type = 1'b0; mem_size = 2'b11;
        unsign = 1'b0; eff_addr = 32'h100; alu_rslt = 32'd0; store_data = 32'd0;
        rd = 5'd0; rt = 5'd0; alu_dst = 2'b00; mem_ack = 1'b0; mem_rdata = 32'd0;
        #3;
        checkOutput("rst_stall", 32'(stall), 32'd0);
        checkOutput("rst_req", 32'(mem_req), 32'd0);
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        @(negedge clk); valid = 1'b0;
        @(negedge clk); rst = 1'b1;

        applyStimulus(32'h1234_5678, 2'b00, 5'd5, 5'd6);
        applyStimulus(32'hCAFE_0001, 2'b01, 5'd7, 5'd9);
        applyStimulus(32'h0000_0042, 2'b10, 5'd3, 5'd4);
        applyStimulus(32'hFFFF_0000, 2'b11, 5'd8, 5'd2);

        mem_instr(1'b0, 2'b00, 1'b0, 32'h103, 32'd0, 32'h80FF_FFFF, 3, 5'd10);
        mem_instr(1'b1, 2'b01, 1'b1, 32'h202, 32'h0000_BEEF, 32'd0, 1, 5'd11);
        mem_instr(1'b0, 2'b11, 1'b0, 32'h400, 32'd0, 32'hCAFE_F00D, 0, 5'd12);
        mem_instr(1'b0, 2'b01, 1'b1, 32'h502, 32'd0, 32'h8001_1234, 2, 5'd13);
        mem_instr(1'b0, 2'b01, 1'b0, 32'h500, 32'd0, 32'h1234_F00D, 1, 5'd14);
        mem_instr(1'b0, 2'b00, 1'b1, 32'h101, 32'd0, 32'h0000_A500, 0, 5'd15);
        mem_instr(1'b1, 2'b00, 1'b0, 32'h601, 32'h1234_5677, 32'd0, 2, 5'd16);
        mem_instr(1'b1, 2'b10, 1'b0, 32'h700, 32'hDEAD_BEEF, 32'd0, 0, 5'd17);
        mem_instr(1'b0, 2'b11, 1'b0, 32'h301, 32'd0, 32'd0, 0, 5'd18);
        mem_instr(1'b1, 2'b01, 1'b0, 32'h203, 32'h1111_2222, 32'd0, 0, 5'd19);
        mem_instr(1'b0, 2'b11, 1'b0, 32'h802, 32'd0, 32'd0, 0, 5'd20);
        applyStimulus(32'h0BAD_F00D, 2'b00, 5'd21, 5'd22);

        // Idle cycles with i_valid low, then a stray ack while idle.
        @(negedge clk); valid = 1'b0; mem_op = 1'b1; mem_ack = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1 checkOutput("idle_no_req", 32'(mem_req), 32'd0);
        end
        @(negedge clk); mem_ack = 1'b0;

        // Reset asserted while waiting on memory abandons the access.
        @(negedge clk);
        valid = 1'b1; mem_op = 1'b1; mem_type = 1'b0; mem_size = 2'b11; eff_addr = 32'h900;
        @(posedge clk);
        #1 checkOutput("pre_rst_req", 32'(mem_req), 32'd1);
        @(negedge clk); rst = 1'b0;
        #1;
        checkOutput("wrst_req", 32'(mem_req), 32'd0);
        checkOutput("wrst_stall", 32'(stall), 32'd0);
        checkOutput("wrst_valid", 32'(out_valid), 32'd0);
        checkOutput("wrst_addr", mem_addr, 32'd0);
        checkOutput("wrst_be", 32'(mem_be), 32'd0);
        checkOutput("wrst_wb_en", 32'(wb_en), 32'd0);
        checkOutput("wrst_wb_data", wb_data, 32'd0);
        @(negedge clk); valid = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
        @(negedge clk); mem_ack = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("post_rst_req", 32'(mem_req), 32'd0);
            checkOutput("post_rst_valid", 32'(out_valid), 32'd0);
            checkOutput("post_rst_stall", 32'(stall), 32'd0);
        end

        repeat (2) @(posedge clk);
        #2 checkOutput("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
